// File: rtl/keypad_entry_controller.sv
// Keypad entry sequencer: debounces scanner codes, edits a BCD digit buffer,
// and on enter converts it to binary and offers it over valid/ready.
//
// state          | meaning
// ---------------+---------------------------------------------------------
// S_IDLE         | no entry in progress; waiting for start
// S_WAIT_RELEASE | counting consecutive released cycles before a new press
// S_WAIT_PRESS   | waiting for key_valid; idle timeout runs here
// S_DEBOUNCE     | key seen; counting consecutive cycles with the same code
// S_ACCEPT       | one cycle: ack the press and apply it to the buffer
// S_CONVERT      | one BCD digit per cycle folded into the binary accumulator
// S_RESULT       | result offered; waiting for result_ready
module keypad_entry_controller #(
    parameter int MAX_DIGITS      = 6,
    parameter int VALUE_W         = 20,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 0
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic                                cancel,
    input  logic [3:0]                          key_code,
    input  logic                                key_valid,
    output logic                                key_ack,
    output logic                                busy,
    output logic [$clog2(MAX_DIGITS+1)-1:0]     digit_count,
    output logic [4*MAX_DIGITS-1:0]             display_bcd,
    output logic                                reject,
    output logic                                timeout,
    output logic                                result_valid,
    input  logic                                result_ready,
    output logic [VALUE_W-1:0]                  result_value,
    output logic [$clog2(MAX_DIGITS+1)-1:0]     result_digits
);

    localparam int DC_W  = $clog2(MAX_DIGITS + 1);
    localparam int BUF_W = 4 * MAX_DIGITS;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [TO_W-1:0]  TO_TC  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [DC_W-1:0]  DC_MAX = DC_W'(MAX_DIGITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RELEASE,
        S_WAIT_PRESS,
        S_DEBOUNCE,
        S_ACCEPT,
        S_CONVERT,
        S_RESULT
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     deb_q, deb_d;
    logic [TO_W-1:0]      idle_q, idle_d;
    logic [3:0]           code_q, code_d;
    logic [BUF_W-1:0]     buf_q, buf_d;
    logic [DC_W-1:0]      dc_q, dc_d;
    logic [DC_W-1:0]      idx_q, idx_d;
    logic [VALUE_W-1:0]   acc_q, acc_d;
    logic [VALUE_W-1:0]   res_value_q, res_value_d;
    logic [DC_W-1:0]      res_digits_q, res_digits_d;
    logic                 key_ack_q, key_ack_d;
    logic                 reject_q, reject_d;
    logic                 timeout_q, timeout_d;
    logic                 busy_q, busy_d;
    logic                 res_valid_q, res_valid_d;

    logic                 reject_ev;
    logic                 timeout_ev;
    logic [CNT_W-1:0]     deb_inc;
    logic [TO_W-1:0]      idle_inc;
    logic [3:0]           conv_digit;
    logic [VALUE_W-1:0]   acc_next;

    // Reject is decided on entry to ACCEPT so it pulses alongside key_ack.
    function automatic logic is_reject(input logic [3:0] code, input logic [DC_W-1:0] cnt);
        logic r;
        r = 1'b0;
        if (code <= 4'd9)       r = (cnt >= DC_MAX);
        else if (code <= 4'd11) r = (cnt == '0);
        else                    r = 1'b1;
        return r;
    endfunction

    assign deb_inc    = deb_q + CNT_W'(1);
    assign idle_inc   = idle_q + TO_W'(1);
    assign conv_digit = 4'(buf_q >> {idx_q, 2'b00});
    assign acc_next   = acc_q * VALUE_W'(10) + VALUE_W'(conv_digit);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            deb_q        <= '0;
            idle_q       <= '0;
            code_q       <= '0;
            buf_q        <= '0;
            dc_q         <= '0;
            idx_q        <= '0;
            acc_q        <= '0;
            res_value_q  <= '0;
            res_digits_q <= '0;
            key_ack_q    <= 1'b0;
            reject_q     <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            deb_q        <= deb_d;
            idle_q       <= idle_d;
            code_q       <= code_d;
            buf_q        <= buf_d;
            dc_q         <= dc_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            res_value_q  <= res_value_d;
            res_digits_q <= res_digits_d;
            key_ack_q    <= key_ack_d;
            reject_q     <= reject_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            res_valid_q  <= res_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        deb_d        = deb_q;
        idle_d       = '0;
        code_d       = code_q;
        buf_d        = buf_q;
        dc_d         = dc_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        res_value_d  = res_value_q;
        res_digits_d = res_digits_q;
        reject_ev    = 1'b0;
        timeout_ev   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT_RELEASE;
                    buf_d   = '0;
                    dc_d    = '0;
                    deb_d   = '0;
                end
            end
            S_WAIT_RELEASE: begin
                if (key_valid) begin
                    deb_d = '0;
                end else if (deb_inc >= DEB_TC) begin
                    state_d = S_WAIT_PRESS;
                    deb_d   = '0;
                end else begin
                    deb_d = deb_inc;
                end
            end
            S_WAIT_PRESS: begin
                if (key_valid) begin
                    code_d = key_code;
                    deb_d  = CNT_W'(1);
                    if (DEBOUNCE_CYCLES <= 1) begin
                        state_d   = S_ACCEPT;
                        deb_d     = '0;
                        reject_ev = is_reject(key_code, dc_q);
                    end else begin
                        state_d = S_DEBOUNCE;
                    end
                end else begin
                    idle_d = idle_inc;
                    if (TIMEOUT_CYCLES != 0 && idle_inc == TO_TC) begin
                        timeout_ev = 1'b1;
                        state_d    = S_IDLE;
                        buf_d      = '0;
                        dc_d       = '0;
                        idle_d     = '0;
                    end
                end
            end
            S_DEBOUNCE: begin
                if (!key_valid || key_code != code_q) begin
                    state_d = S_WAIT_PRESS;
                    deb_d   = '0;
                end else if (deb_inc >= DEB_TC) begin
                    state_d   = S_ACCEPT;
                    deb_d     = '0;
                    reject_ev = is_reject(code_q, dc_q);
                end else begin
                    deb_d = deb_inc;
                end
            end
            S_ACCEPT: begin
                state_d = S_WAIT_RELEASE;
                deb_d   = '0;
                if (code_q <= 4'd9) begin
                    if (dc_q < DC_MAX) begin
                        buf_d = (buf_q << 4) | BUF_W'(code_q);
                        dc_d  = dc_q + DC_W'(1);
                    end
                end else if (code_q == 4'd10) begin
                    if (dc_q != '0) begin
                        buf_d = buf_q >> 4;
                        dc_d  = dc_q - DC_W'(1);
                    end
                end else if (code_q == 4'd11) begin
                    if (dc_q != '0) begin
                        state_d = S_CONVERT;
                        acc_d   = '0;
                        idx_d   = dc_q - DC_W'(1);
                    end
                end
            end
            S_CONVERT: begin
                acc_d = acc_next;
                if (idx_q == '0) begin
                    res_value_d  = acc_next;
                    res_digits_d = dc_q;
                    state_d      = S_RESULT;
                end else begin
                    idx_d = idx_q - DC_W'(1);
                end
            end
            S_RESULT: begin
                if (result_ready) begin
                    state_d = S_IDLE;
                    buf_d   = '0;
                    dc_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (cancel) begin
            state_d    = S_IDLE;
            buf_d      = '0;
            dc_d       = '0;
            deb_d      = '0;
            idle_d     = '0;
            reject_ev  = 1'b0;
            timeout_ev = 1'b0;
        end
    end

    always_comb begin
        key_ack_d   = (state_d == S_ACCEPT);
        reject_d    = reject_ev;
        timeout_d   = timeout_ev;
        busy_d      = (state_d != S_IDLE);
        res_valid_d = (state_d == S_RESULT);
    end

    assign key_ack       = key_ack_q;
    assign reject        = reject_q;
    assign timeout       = timeout_q;
    assign busy          = busy_q;
    assign result_valid  = res_valid_q;
    assign digit_count   = dc_q;
    assign display_bcd   = buf_q;
    assign result_value  = res_value_q;
    assign result_digits = res_digits_q;

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Self-checking bench for keypad_entry_controller: directed vector table,
// multi-cycle corner sequences, and random entries against a digit-queue model.
module tb_keypad_entry_controller;

    localparam int MAXD = 6;
    localparam int VW   = 20;
    localparam int DEB  = 4;
    localparam int TO   = 100;
    localparam int DCW  = $clog2(MAXD + 1);
    localparam int BW   = 4 * MAXD;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic            cancel = 1'b0;
    logic [3:0]      key_code = 4'd0;
    logic            key_valid = 1'b0;
    logic            result_ready = 1'b0;
    logic            key_ack, busy, reject, timeout, result_valid;
    logic [DCW-1:0]  digit_count, result_digits;
    logic [BW-1:0]   display_bcd;
    logic [VW-1:0]   result_value;

    keypad_entry_controller #(
        .MAX_DIGITS(MAXD), .VALUE_W(VW), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .cancel(cancel),
        .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack), .busy(busy),
        .digit_count(digit_count), .display_bcd(display_bcd), .reject(reject),
        .timeout(timeout), .result_valid(result_valid), .result_ready(result_ready),
        .result_value(result_value), .result_digits(result_digits)
    );

    always #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ack_cnt = 0, rej_cnt = 0, to_cnt = 0, rv_rise_cnt = 0;
    int   last_ack_cyc = 0, rv_rise_cyc = 0;
    logic rv_prev = 1'b0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (key_ack) begin
            ack_cnt++;
            last_ack_cyc = cyc;
        end
        if (reject)  rej_cnt++;
        if (timeout) to_cnt++;
        if (result_valid && !rv_prev) begin
            rv_rise_cnt++;
            rv_rise_cyc = cyc;
        end
        rv_prev = result_valid;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press_key(input int c, input int hold, input int rel);
        key_code  = 4'(c);
        key_valid = 1'b1;
        ticks(hold);
        key_valid = 1'b0;
        ticks(rel);
    endtask

    // Short pulses, each below the debounce length.
    task automatic bounce(input int c, input int pulses);
        repeat (pulses) begin
            key_code  = 4'(c);
            key_valid = 1'b1;
            ticks(2);
            key_valid = 1'b0;
            ticks(2);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(DEB + 2);
    endtask

    task automatic press_check(input string name, input int c, input int exp_rej,
                               input int exp_cnt, input longint exp_disp);
        int a0, r0;
        a0 = ack_cnt;
        r0 = rej_cnt;
        press_key(c, 6, 6);
        check({name, ".ack"}, ack_cnt - a0, 1);
        check({name, ".reject"}, rej_cnt - r0, exp_rej);
        check({name, ".count"}, digit_count, exp_cnt);
        check({name, ".display"}, display_bcd, exp_disp);
        check({name, ".busy"}, busy, 1);
    endtask

    task automatic take_result(input string name, input longint exp_val,
                               input int exp_dig, input int stall);
        int   w;
        logic stable;
        w = 0;
        while (!result_valid && w < 50) begin
            tick();
            w++;
        end
        check({name, ".valid_seen"}, result_valid, 1);
        check({name, ".value"}, result_value, exp_val);
        check({name, ".digits"}, result_digits, exp_dig);
        stable = 1'b1;
        repeat (stall) begin
            tick();
            if (!result_valid || result_value != VW'(exp_val) || result_digits != DCW'(exp_dig))
                stable = 1'b0;
        end
        check({name, ".held"}, stable, 1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check({name, ".valid_drop"}, result_valid, 0);
        check({name, ".idle"}, busy, 0);
        check({name, ".value_kept"}, result_value, exp_val);
        check({name, ".cleared"}, digit_count, 0);
        check({name, ".latency"}, rv_rise_cyc - last_ack_cyc, exp_dig + 1);
    endtask

    function automatic longint model_disp(input int q[$]);
        longint d = 0;
        foreach (q[i]) d = d * 16 + q[i];
        return d;
    endfunction

    function automatic longint model_value(input int q[$]);
        longint v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        return v;
    endfunction

    typedef struct {
        int     code;
        int     rej;
        int     cnt;
        longint disp;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int a0, r0, t0, v0, w;
        int q[$];

        tbl[0]  = '{9,  0, 1, 'h9};
        tbl[1]  = '{8,  0, 2, 'h98};
        tbl[2]  = '{10, 0, 1, 'h9};
        tbl[3]  = '{10, 0, 0, 'h0};
        tbl[4]  = '{10, 1, 0, 'h0};
        tbl[5]  = '{11, 1, 0, 'h0};
        tbl[6]  = '{13, 1, 0, 'h0};
        tbl[7]  = '{1,  0, 1, 'h1};
        tbl[8]  = '{2,  0, 2, 'h12};
        tbl[9]  = '{3,  0, 3, 'h123};
        tbl[10] = '{4,  0, 4, 'h1234};
        tbl[11] = '{5,  0, 5, 'h12345};
        tbl[12] = '{6,  0, 6, 'h123456};
        tbl[13] = '{7,  1, 6, 'h123456};
        tbl[14] = '{10, 0, 5, 'h12345};
        tbl[15] = '{6,  0, 6, 'h123456};
        tbl[16] = '{15, 1, 6, 'h123456};

        ticks(3);
        reset_n = 1'b1;
        tick();
        check("reset.outputs",
              {key_ack, busy, reject, timeout, result_valid, digit_count, display_bcd,
               result_value, result_digits}, 0);

        // Basic entry 1,2,3,#
        do_start();
        check("basic.busy", busy, 1);
        a0 = ack_cnt;
        press_check("basic.k1", 1, 0, 1, 'h1);
        press_check("basic.k2", 2, 0, 2, 'h12);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("basic.start_ignored", digit_count, 2);
        press_check("basic.k3", 3, 0, 3, 'h123);
        check("basic.low_nibble", display_bcd[3:0], 3);
        press_key(11, 6, 6);
        check("basic.ack_total", ack_cnt - a0, 4);
        take_result("basic.res", 123, 3, 0);

        // Bounce, then exact-length holds either side of the threshold
        do_start();
        a0 = ack_cnt;
        bounce(5, 5);
        check("bounce.no_ack", ack_cnt - a0, 0);
        press_key(5, 4, 6);
        check("bounce.one_ack", ack_cnt - a0, 1);
        check("bounce.count", digit_count, 1);
        check("bounce.nibble", display_bcd[3:0], 5);
        a0 = ack_cnt;
        press_key(6, 3, 6);
        check("short_hold.no_ack", ack_cnt - a0, 0);
        check("short_hold.count", digit_count, 1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("bounce.cancel_idle", busy, 0);
        check("bounce.cancel_count", digit_count, 0);

        // Backspace, rejects, overflow, then backpressured result
        do_start();
        foreach (tbl[i])
            press_check($sformatf("table[%0d]", i), tbl[i].code, tbl[i].rej, tbl[i].cnt, tbl[i].disp);
        press_key(11, 6, 6);
        take_result("table.res", 123456, 6, 10);

        // Random entries against the digit-queue model
        for (int e = 0; e < 20; e++) begin
            int     code, r, exp_rej;
            logic   done;
            do_start();
            q.delete();
            done = 1'b0;
            for (int p = 0; p < 12 && !done; p++) begin
                r = $urandom_range(0, 20);
                if (r < 12)       code = r % 10;
                else if (r < 15)  code = 10;
                else if (r < 17)  code = 11;
                else              code = 12 + (r - 17);
                bounce(code, $urandom_range(0, 2));
                if (code == 11 && q.size() > 0) begin
                    press_key(11, 6, 6);
                    take_result($sformatf("rand[%0d].res", e), model_value(q), q.size(),
                                $urandom_range(0, 4));
                    done = 1'b1;
                end else begin
                    exp_rej = 0;
                    if (code <= 9) begin
                        if (q.size() < MAXD) q.push_back(code);
                        else exp_rej = 1;
                    end else if (code == 10) begin
                        if (q.size() > 0) void'(q.pop_back());
                        else exp_rej = 1;
                    end else begin
                        exp_rej = 1;
                    end
                    press_check($sformatf("rand[%0d].p%0d", e, p), code, exp_rej,
                                q.size(), model_disp(q));
                end
            end
            if (!done) begin
                if (q.size() == 0) begin
                    q.push_back(5);
                    press_check($sformatf("rand[%0d].pad", e), 5, 0, 1, 'h5);
                end
                press_key(11, 6, 6);
                take_result($sformatf("rand[%0d].res", e), model_value(q), q.size(), 0);
            end
        end

        // Idle timeout in WAIT_PRESS
        do_start();
        press_key(4, 6, 6);
        t0 = to_cnt;
        ticks(90);
        check("timeout.not_yet", to_cnt - t0, 0);
        check("timeout.still_busy", busy, 1);
        ticks(20);
        check("timeout.one_pulse", to_cnt - t0, 1);
        check("timeout.idle", busy, 0);
        check("timeout.count", digit_count, 0);
        check("timeout.display", display_bcd, 0);

        // Cancel during CONVERT
        do_start();
        press_key(1, 6, 6);
        press_key(2, 6, 6);
        press_key(3, 6, 6);
        key_code  = 4'd11;
        key_valid = 1'b1;
        w = 0;
        while (!key_ack && w < 20) begin
            tick();
            w++;
        end
        check("cancel.hash_ack", key_ack, 1);
        tick();
        check("cancel.converting", busy, 1);
        v0 = rv_rise_cnt;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        key_valid = 1'b0;
        check("cancel.idle", busy, 0);
        check("cancel.count", digit_count, 0);
        check("cancel.valid", result_valid, 0);
        ticks(15);
        check("cancel.no_result", rv_rise_cnt - v0, 0);

        // Async reset mid-DEBOUNCE
        do_start();
        press_key(7, 6, 6);
        key_code  = 4'd8;
        key_valid = 1'b1;
        ticks(2);
        check("rst.pre_count", digit_count, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst.outputs",
              {key_ack, busy, reject, timeout, result_valid, digit_count, display_bcd,
               result_value, result_digits}, 0);
        key_valid = 1'b0;
        ticks(2);
        reset_n = 1'b1;
        tick();
        check("rst.idle_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_entry_controller.md
Name: keypad_entry_controller

Overview:
- Sequences the 3x4 keypad scanner for the ATM front end.
- Debounces the scanner's key code and accepts exactly one event per physical press, returning an ack pulse to the scanner.
- Accumulates up to MAX_DIGITS decimal digits. '*' is backspace; '#' is enter.
- On enter, converts the BCD buffer to binary and hands the value to the processor over a valid/ready handshake.

Parameters:
- MAX_DIGITS, 6, maximum digits held in the entry buffer.
- VALUE_W, 20, width of result_value; must hold 10^MAX_DIGITS-1.
- DEBOUNCE_CYCLES, 1000000, consecutive stable clock cycles needed to accept a press or a release.
- TIMEOUT_CYCLES, 0, idle cycles in WAIT_PRESS before the entry is abandoned; 0 disables the timeout.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin an entry; ignored unless state is IDLE.
- cancel  in  1  abort the entry and clear all buffers; honoured in any state.
- key_code  in  4  scanner code: 0-9 digits, 10 '*', 11 '#', 12-15 invalid.
- key_valid  in  1  high while the scanner reports a key held.
- key_ack  out  1  one-cycle pulse when a press is accepted (valid or rejected).
- busy  out  1  high in every state except IDLE.
- digit_count  out  $clog2(MAX_DIGITS+1)  digits currently buffered.
- display_bcd  out  4*MAX_DIGITS  buffer contents; [3:0] holds the newest, least significant digit.
- reject  out  1  one-cycle pulse on an accepted-but-ignored key.
- timeout  out  1  one-cycle pulse when the entry times out.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- result_value  out  VALUE_W  binary value of the entered digits.
- result_digits  out  $clog2(MAX_DIGITS+1)  digit count of the result.

Behaviour:

Reset and outputs
- Reset (async assert, sync deassert) enters IDLE. All counters, buffers and outputs are 0.
- Outputs are registered.

State machine: IDLE, WAIT_RELEASE, WAIT_PRESS, DEBOUNCE, ACCEPT, CONVERT, RESULT.

- IDLE
  - start=1 → WAIT_RELEASE; buffer and digit_count cleared.
  - key_valid is ignored.
- WAIT_RELEASE
  - Counts consecutive key_valid=0 cycles; any key_valid=1 resets the count.
  - Count reaches DEBOUNCE_CYCLES → WAIT_PRESS.
- WAIT_PRESS
  - key_valid=1 → DEBOUNCE; the code is latched and the counter is set to 1.
  - The idle counter increments each cycle here and clears on leaving WAIT_PRESS.
  - If TIMEOUT_CYCLES≠0 and the idle counter reaches TIMEOUT_CYCLES: pulse timeout, clear the buffer, go to IDLE.
- DEBOUNCE
  - key_valid=0 or key_code≠latched code → WAIT_PRESS; no ack.
  - Counter reaches DEBOUNCE_CYCLES → ACCEPT.
  - Acceptance latency is DEBOUNCE_CYCLES cycles from the first valid sample.
- ACCEPT (one cycle)
  - key_ack=1 for this cycle only.
  - Digit with digit_count<MAX_DIGITS: shift buffer left 4, insert digit at [3:0], digit_count+1.
  - Digit with the buffer full: reject.
  - '*' with digit_count>0: shift buffer right 4, clear the top nibble, digit_count−1.
  - '*' with digit_count=0: reject.
  - '#' with digit_count>0 → CONVERT; accumulator and index initialised.
  - '#' with digit_count=0: reject.
  - Codes 12-15: reject.
  - Every case except a successful '#' → WAIT_RELEASE.
- CONVERT
  - One digit per cycle, most significant first: acc ← acc*10 + digit.
  - Takes exactly digit_count cycles, then loads result_value and result_digits and goes to RESULT.
  - result_valid rises digit_count+1 cycles after the '#' ACCEPT cycle.
  - Key activity during CONVERT is ignored.
- RESULT
  - result_valid and result fields are held stable while result_ready=0.
  - The cycle with result_ready=1 is the transfer; next cycle result_valid=0 and state is IDLE.
  - The buffer is cleared on transfer; result_value holds its last value.

Global rules
- cancel has priority over every other event: next cycle is IDLE with buffer, digit_count and result_valid cleared, and no ack or pulse.
- start while busy is ignored.
- The arithmetic width is VALUE_W. Overflow cannot occur when parameters are legal.

Test Plan:
(DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100, MAX_DIGITS=6.)
1. Basic entry: start; clean presses 1, 2, 3, '#' (each held ≥4 cycles, released ≥4 cycles) → four key_ack pulses; display_bcd low nibbles 3,2,1 before '#'; result_valid 4 cycles after the '#' ACCEPT; result_value=123, result_digits=3.
2. Bounce: key 5 toggling every 2 cycles for 20 cycles, then held 4 → exactly one ack; digit_count=1; display_bcd[3:0]=5.
3. Backspace and rejects: press 9, 8, '*' → digit_count=1, display 9. '*' '*' → second '*' rejects. '#' on empty → reject, busy stays 1.
4. Overflow: press 1-6 then 7 → seventh press pulses reject and the buffer stays 123456. '#' → result_value=123456.
5. Backpressure: result_ready=0 for 10 cycles after result_valid → value stable and valid held. Ready pulse → valid drops the next cycle; busy=0.
6. Abort paths:
   - No key for 100 cycles in WAIT_PRESS → one timeout pulse, IDLE, digit_count=0.
   - cancel during CONVERT → IDLE next cycle, result_valid never asserts.
   - reset_n low mid-DEBOUNCE → all outputs 0 immediately.
